// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA timing decoder: default 640x480 mode,
// derived totals and the lock FSM state encoding.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE   = 640;
    localparam int unsigned DEF_H_FRONT     = 16;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_BACK      = 48;
    localparam int unsigned DEF_V_VISIBLE   = 480;
    localparam int unsigned DEF_V_FRONT     = 10;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BACK      = 33;
    localparam int unsigned DEF_LOCK_FRAMES = 2;

    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam logic [11:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Saturating increment for the 12-bit raster counters.
    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input; reset value is selectable so
// the chain can start at the idle level of the line it guards.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers raster position from raw hsync/vsync, measures line/frame length and
// tracks lock against the configured video mode.
module vga_timing_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE       = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT         = DEF_H_FRONT,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_BACK          = DEF_H_BACK,
    parameter int unsigned V_VISIBLE       = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT         = DEF_V_FRONT,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_BACK          = DEF_V_BACK,
    parameter int unsigned SYNC_ACTIVE_LOW = 1,
    parameter int unsigned LOCK_FRAMES     = DEF_LOCK_FRAMES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        visible,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [11:0] h_total_meas,
    output logic [11:0] v_total_meas
);

    localparam logic [12:0] H_TOTAL_C = 13'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [12:0] V_TOTAL_C = 13'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [12:0] H_SYNC_C  = 13'(H_SYNC);
    localparam logic [11:0] HOFF      = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] HEND      = 12'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [11:0] VOFF      = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] VEND      = 12'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic        POL       = (SYNC_ACTIVE_LOW != 0);
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);

    logic        hs_sync, vs_sync;
    logic        hs_cur, hs_prev, vs_cur, vs_prev;
    logic        hs_rise, hs_fall, vs_rise;
    logic [11:0] hcnt, vcnt;
    logic [12:0] hcnt_p1, frame_len;
    logic [11:0] h_meas_nxt, v_meas_nxt;
    logic        h_err_c, v_err_c, any_err, frame_bad, hs_lost;
    logic        hvis, vvis;
    state_t      state, state_nxt;
    logic [7:0]  good_cnt, good_nxt, good_inc;
    logic        err_flag, flag_nxt;

    // Synchroniser chains idle at the inactive pin level so reset never fakes an edge.
    sync_2ff #(.RESET_VAL(POL)) u_hs_sync (
        .clock (clock),
        .reset (reset),
        .d     (hsync_in),
        .q     (hs_sync)
    );

    sync_2ff #(.RESET_VAL(POL)) u_vs_sync (
        .clock (clock),
        .reset (reset),
        .d     (vsync_in),
        .q     (vs_sync)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_cur  <= 1'b0;
            hs_prev <= 1'b0;
            vs_cur  <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            hs_cur  <= hs_sync ^ POL;
            hs_prev <= hs_cur;
            vs_cur  <= vs_sync ^ POL;
            vs_prev <= vs_cur;
        end
    end

    assign hs_rise = hs_cur & ~hs_prev;
    assign hs_fall = ~hs_cur & hs_prev;
    assign vs_rise = vs_cur & ~vs_prev;

    assign hcnt_p1    = {1'b0, hcnt} + 13'd1;
    assign frame_len  = {1'b0, vcnt} + {12'd0, hs_rise};
    assign h_meas_nxt = hcnt_p1[12] ? CNT_MAX : hcnt_p1[11:0];
    assign v_meas_nxt = frame_len[12] ? CNT_MAX : frame_len[11:0];

    assign h_err_c = (hs_rise && (hcnt_p1 != H_TOTAL_C)) ||
                     (hs_fall && (hcnt_p1 != H_SYNC_C));
    assign v_err_c = vs_rise && (frame_len != V_TOTAL_C);
    assign any_err = h_err_c | v_err_c;

    assign hvis = (hcnt >= HOFF) && (hcnt < HEND);
    assign vvis = (vcnt >= VOFF) && (vcnt < VEND);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hcnt         <= '0;
            vcnt         <= '0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            h_err        <= 1'b0;
            v_err        <= 1'b0;
        end else begin
            hcnt  <= hs_rise ? '0 : sat_inc(hcnt);
            h_err <= h_err_c;
            v_err <= v_err_c;
            if (vs_rise) begin
                vcnt <= '0;
            end else if (hs_rise) begin
                vcnt <= sat_inc(vcnt);
            end
            if (hs_rise) begin
                h_total_meas <= h_meas_nxt;
            end
            if (vs_rise) begin
                v_total_meas <= v_meas_nxt;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x       <= '0;
            y       <= '0;
            visible <= 1'b0;
        end else begin
            x       <= hvis ? (hcnt - HOFF) : '0;
            y       <= vvis ? (vcnt - VOFF) : '0;
            visible <= hvis & vvis & locked;
        end
    end

    assign good_inc  = good_cnt + 8'd1;
    assign frame_bad = err_flag | any_err;
    // A returning hs_rise clears the lost condition even while hcnt is still saturated.
    assign hs_lost   = (hcnt == CNT_MAX) && !hs_rise;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        flag_nxt  = vs_rise ? 1'b0 : (err_flag | any_err);
        case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_nxt = TRAIN;
                    good_nxt  = '0;
                end
            end
            TRAIN: begin
                if (vs_rise) begin
                    if (frame_bad) begin
                        good_nxt = '0;
                    end else begin
                        good_nxt = good_inc;
                        if (good_inc >= LOCK_N) begin
                            state_nxt = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_nxt = TRAIN;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
            end
        endcase
        if (hs_lost) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
            flag_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= SEARCH;
            good_cnt <= '0;
            err_flag <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            err_flag <= flag_nxt;
            locked   <= (state == LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Scoreboard bench for vga_timing_decoder using a reduced video mode so that
// complete frames fit in a short run.
module tb_vga_timing_decoder;
    import vga_timing_pkg::*;

    localparam int unsigned HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int unsigned VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int unsigned HT = HV + HF + HS + HB;   // 25
    localparam int unsigned VT = VV + VF + VS + VB;   // 11

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] x, y, h_total_meas, v_total_meas;
    logic        visible, locked, h_err, v_err;

    vga_timing_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .visible(visible), .locked(locked), .h_err(h_err), .v_err(v_err),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic val;
        logic by_err;
    } lock_ev_t;

    int unsigned herr_q[$];
    int unsigned verr_q[$];
    int unsigned vis_q[$];
    lock_ev_t    lock_q[$];

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int unsigned info);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event (value %0d), none expected", name, info);
    endtask

    // One line: hsync active for the first 'width' clocks, vsync held for the whole line.
    task automatic send_line(input int unsigned len, input int unsigned width, input logic vs_act);
        for (int unsigned p = 0; p < len; p++) begin
            @(posedge clock);
            #1;
            hsync_in = (p < width) ? 1'b0 : 1'b1;
            vsync_in = vs_act ? 1'b0 : 1'b1;
        end
    endtask

    task automatic send_frame(input int unsigned lines, input int unsigned width,
                              input int unsigned short_idx);
        for (int unsigned l = 0; l < lines; l++) begin
            send_line((l == short_idx) ? HT - 1 : HT, width, l < VS);
        end
    endtask

    task automatic push_rows();
        for (int unsigned r = 0; r < VV; r++) vis_q.push_back(r);
    endtask

    // First frame after reset: startup strobes are unchecked, then monitoring begins.
    task automatic startup_frame();
        send_line(HT, HS, 1'b1);
        mon_en = 1'b1;
        for (int unsigned l = 1; l < VT; l++) send_line(HT, HS, l < VS);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_visible"}, 32'(visible), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_h_err"}, 32'(h_err), 0);
        chk({tag, "_v_err"}, 32'(v_err), 0);
        chk({tag, "_h_meas"}, 32'(h_total_meas), 0);
        chk({tag, "_v_meas"}, 32'(v_total_meas), 0);
    endtask

    // Monitor: pops the matching queue whenever the DUT presents an event.
    int unsigned cyc = 0;
    int unsigned last_err = 0;
    int unsigned vis_len = 0;
    logic [11:0] vis_y = '0;
    logic [11:0] prev_x = '0;
    logic        prev_locked = 1'b0;
    logic        prev_vis = 1'b0;

    always @(negedge clock) begin
        lock_ev_t    le;
        int unsigned ev;
        cyc++;
        if (mon_en) begin
            if (h_err) begin
                last_err = cyc;
                if (herr_q.size() == 0) unexpected("h_err", 32'(h_total_meas));
                else begin
                    ev = herr_q.pop_front();
                    chk("h_err_meas", 32'(h_total_meas), ev);
                end
            end
            if (v_err) begin
                last_err = cyc;
                if (verr_q.size() == 0) unexpected("v_err", 32'(v_total_meas));
                else begin
                    ev = verr_q.pop_front();
                    chk("v_err_meas", 32'(v_total_meas), ev);
                end
            end
            if (locked != prev_locked) begin
                if (lock_q.size() == 0) unexpected("locked_change", 32'(locked));
                else begin
                    le = lock_q.pop_front();
                    chk("locked_val", 32'(locked), 32'(le.val));
                    if (le.by_err) chk("unlock_delay", cyc - last_err, 1);
                end
            end
            if (visible && !prev_vis) begin
                chk("vis_first_x", 32'(x), 0);
                vis_len = 1;
                vis_y = y;
            end else if (visible) begin
                vis_len++;
            end
            if (!visible && prev_vis) begin
                if (vis_q.size() == 0) unexpected("visible_line", 32'(vis_y));
                else begin
                    ev = vis_q.pop_front();
                    chk("vis_row_y", 32'(vis_y), ev);
                    chk("vis_row_len", vis_len, HV);
                    chk("vis_last_x", 32'(prev_x), HV - 1);
                end
            end
        end
        prev_locked = locked;
        prev_vis = visible;
        prev_x = x;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        chk("reset_state", 32'(dut.state), 32'(SEARCH));
        @(posedge clock);
        #1;
        reset = 1'b1;

        // 1: clean loopback, lock after the second full frame
        startup_frame();
        lock_q.push_back('{1'b1, 1'b0});
        send_frame(VT, HS, VT);
        push_rows();
        send_frame(VT, HS, VT);
        chk("t1_h_meas", 32'(h_total_meas), HT);
        chk("t1_v_meas", 32'(v_total_meas), VT);
        chk("t1_locked", 32'(locked), 1);

        // 2: one short line while locked, relock after two clean frames
        herr_q.push_back(HT - 1);
        lock_q.push_back('{1'b0, 1'b1});
        lock_q.push_back('{1'b1, 1'b0});
        send_frame(VT, HS, 0);
        chk("t2_unlocked", 32'(locked), 0);
        send_frame(VT, HS, VT);
        send_frame(VT, HS, VT);
        push_rows();
        send_frame(VT, HS, VT);
        chk("t2_relocked", 32'(locked), 1);

        // 3: hsync one clock too narrow for three frames
        lock_q.push_back('{1'b0, 1'b1});
        for (int unsigned i = 0; i < 3 * VT; i++) herr_q.push_back(HT);
        for (int unsigned f = 0; f < 3; f++) send_frame(VT, HS - 1, VT);
        chk("t3_unlocked", 32'(locked), 0);
        lock_q.push_back('{1'b1, 1'b0});
        send_frame(VT, HS, VT);
        send_frame(VT, HS, VT);
        push_rows();
        send_frame(VT, HS, VT);

        // 4: one frame a line short while locked
        push_rows();
        verr_q.push_back(VT - 1);
        lock_q.push_back('{1'b0, 1'b1});
        lock_q.push_back('{1'b1, 1'b0});
        send_frame(VT - 1, HS, VT);
        send_frame(VT, HS, VT);
        chk("t4_v_meas", 32'(v_total_meas), VT - 1);
        chk("t4_good_restart", 32'(dut.good_cnt), 0);
        send_frame(VT, HS, VT);
        chk("t4_good_one", 32'(dut.good_cnt), 1);
        push_rows();
        send_frame(VT, HS, VT);

        // 5: hsync lost for more than 4096 clocks
        lock_q.push_back('{1'b0, 1'b0});
        for (int unsigned i = 0; i < 4200; i++) begin
            @(posedge clock);
            #1;
            hsync_in = 1'b1;
            vsync_in = 1'b1;
        end
        chk("t5_locked", 32'(locked), 0);
        chk("t5_visible", 32'(visible), 0);
        chk("t5_state", 32'(dut.state), 32'(SEARCH));
        herr_q.push_back(4095);
        send_frame(VT, HS, VT);
        send_frame(VT, HS, VT);
        lock_q.push_back('{1'b1, 1'b0});

        // 6: asynchronous reset mid-line while locked
        vis_q.push_back(0);
        for (int unsigned l = 0; l < 5; l++) send_line(HT, HS, l < VS);
        send_line(6, HS, 1'b0);
        chk("t6_locked_before", 32'(locked), 1);
        mon_en = 1'b0;
        #1;
        reset = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        #1;
        check_all_zero("t6_async");
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        startup_frame();
        lock_q.push_back('{1'b1, 1'b0});
        send_frame(VT, HS, VT);
        push_rows();
        send_frame(VT, HS, VT);
        repeat (20) @(posedge clock);
        #1;

        chk("left_herr", herr_q.size(), 0);
        chk("left_verr", verr_q.size(), 0);
        chk("left_lock", lock_q.size(), 0);
        chk("left_vis", vis_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
